// File: rtl/servo_pkg.sv
// -----------------------------------------------------------------------------
// servo_pkg
// Shared definitions for the two-channel servo PWM scheduler:
//   state_e     - scheduler states (IDLE, RUN, UPDATE)
//   pulse_us_t  - 16-bit pulse width in microseconds
//   DEF_*       - default parameter values
//   clamp_us()  - saturate a pulse width into [lo, hi]
// -----------------------------------------------------------------------------
package servo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        UPDATE = 2'd2
    } state_e;

    typedef logic [15:0] pulse_us_t;

    localparam int unsigned DEF_CLK_HZ    = 50_000_000;
    localparam int unsigned DEF_FRAME_US  = 20_000;
    localparam int unsigned DEF_MIN_US    = 1_000;
    localparam int unsigned DEF_MAX_US    = 2_000;
    localparam int unsigned DEF_CENTER_US = 1_500;
    localparam int unsigned DEF_SLEW_US   = 20;

    function automatic pulse_us_t clamp_us(input pulse_us_t v,
                                           input pulse_us_t lo,
                                           input pulse_us_t hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/servo_slew.sv
// -----------------------------------------------------------------------------
// servo_slew
// One servo channel: holds the commanded target (clamped on load) and the
// applied pulse width, which moves toward the target by at most SLEW_US each
// time step_i is asserted.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   load_i        - store cmd_us_i (after clamping) as the new target
//   cmd_us_i      - requested pulse width in us
//   step_i        - advance pos one slew step toward target this clock
//   pos_o         - applied pulse width (registered)
//   pos_d_o       - value pos_o takes at the next clock edge
// -----------------------------------------------------------------------------
module servo_slew
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US    = DEF_MIN_US,
    parameter int unsigned MAX_US    = DEF_MAX_US,
    parameter int unsigned CENTER_US = DEF_CENTER_US,
    parameter int unsigned SLEW_US   = DEF_SLEW_US
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load_i,
    input  pulse_us_t cmd_us_i,
    input  logic      step_i,
    output pulse_us_t pos_o,
    output pulse_us_t pos_d_o
);

    localparam pulse_us_t MIN_P    = pulse_us_t'(MIN_US);
    localparam pulse_us_t MAX_P    = pulse_us_t'(MAX_US);
    localparam pulse_us_t CENTER_P = pulse_us_t'(CENTER_US);
    localparam pulse_us_t SLEW_P   = pulse_us_t'(SLEW_US);

    pulse_us_t   target_q, target_d;
    pulse_us_t   pos_q, pos_d;
    logic        up;
    logic [16:0] gap;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        target_d = target_q;
        pos_d    = pos_q;
        up       = (target_q >= pos_q);
        // Distance is formed in 17 bits on the larger-minus-smaller side, so
        // it can never wrap regardless of which way the servo has to move.
        gap      = up ? ({1'b0, target_q} - {1'b0, pos_q})
                      : ({1'b0, pos_q} - {1'b0, target_q});

        if (load_i) begin
            target_d = clamp_us(cmd_us_i, MIN_P, MAX_P);
        end

        if (step_i) begin
            if (gap <= 17'(SLEW_US)) begin
                pos_d = target_q;
            end else if (up) begin
                pos_d = pos_q + SLEW_P;
            end else begin
                pos_d = pos_q - SLEW_P;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= CENTER_P;
            pos_q    <= CENTER_P;
        end else begin
            // NOTE: sequential state uses <= so every register samples the
            // values that existed before this edge.
            target_q <= target_d;
            pos_q    <= pos_d;
        end
    end

    assign pos_o   = pos_q;
    assign pos_d_o = pos_d;

endmodule

// File: rtl/servo_pwm_scheduler.sv
// -----------------------------------------------------------------------------
// servo_pwm_scheduler
// Two-channel hobby-servo PWM generator. A prescaler produces a 1 us tick,
// us_cnt counts the frame, and a small FSM inserts a one-clock UPDATE at the
// start of every frame where the applied pulse widths slew toward their
// commanded targets. Commands are accepted in IDLE and RUN only.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   enable         - run the PWM when high; low forces IDLE
//   cmd_valid      - command strobe; transfer when cmd_valid && cmd_ready
//   cmd_ready      - low only during the UPDATE clock
//   cmd_ch         - target channel (0 or 1)
//   cmd_us         - requested pulse width in us (clamped to MIN_US..MAX_US)
//   servo_out[1:0] - registered PWM outputs, bit n = channel n
//   pos_0, pos_1   - applied pulse widths in us
//   frame_start    - high exactly during the UPDATE clock
// -----------------------------------------------------------------------------
module servo_pwm_scheduler
    import servo_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned FRAME_US  = DEF_FRAME_US,
    parameter int unsigned MIN_US    = DEF_MIN_US,
    parameter int unsigned MAX_US    = DEF_MAX_US,
    parameter int unsigned CENTER_US = DEF_CENTER_US,
    parameter int unsigned SLEW_US   = DEF_SLEW_US
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_ch,
    input  logic [15:0] cmd_us,
    output logic [1:0]  servo_out,
    output logic [15:0] pos_0,
    output logic [15:0] pos_1,
    output logic        frame_start
);

    localparam int unsigned DIV   = CLK_HZ / 1_000_000;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned CNT_W = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_US - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] us_cnt_q, us_cnt_d;
    logic [1:0]       servo_q, servo_d;
    logic             tick, wrap, xfer;
    pulse_us_t        pos0_q, pos0_d, pos1_q, pos1_d;

    assign tick = (pre_q == PRE_LAST);
    assign wrap = tick && (us_cnt_q == CNT_LAST);
    assign xfer = cmd_valid && cmd_ready;

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d     = state_q;
        cmd_ready   = 1'b1;
        frame_start = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                // Leaving IDLE goes through UPDATE so the first frame starts
                // cleanly at us_cnt = 0 with a frame_start pulse.
                IDLE:    state_d = UPDATE;
                RUN:     if (wrap) state_d = UPDATE;
                UPDATE:  state_d = RUN;
                default: state_d = IDLE;
            endcase
        end

        if (state_q == UPDATE) begin
            cmd_ready   = 1'b0;
            frame_start = 1'b1;
        end
    end

    // ------------------------------------------------------------ counters
    // UPDATE is the first clock of a frame, so the counters keep running
    // through it; every frame is therefore exactly FRAME_US ticks long.
    always_comb begin
        pre_d    = pre_q;
        us_cnt_d = us_cnt_q;
        if (state_q == IDLE || !enable) begin
            pre_d    = '0;
            us_cnt_d = '0;
        end else if (tick) begin
            pre_d    = '0;
            us_cnt_d = wrap ? '0 : us_cnt_q + CNT_W'(1);
        end else begin
            pre_d    = pre_q + PRE_W'(1);
        end
    end

    // --------------------------------------------------------- PWM compare
    // Compare against next-state values so the registered output lines up
    // with the us_cnt / pos it is registered alongside.
    always_comb begin
        servo_d = 2'b00;
        if (state_d != IDLE) begin
            servo_d[0] = (32'(us_cnt_d) < 32'(pos0_d));
            servo_d[1] = (32'(us_cnt_d) < 32'(pos1_d));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            us_cnt_q <= '0;
            servo_q  <= 2'b00;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            us_cnt_q <= us_cnt_d;
            servo_q  <= servo_d;
        end
    end

    // ------------------------------------------------------------ channels
    servo_slew #(
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .CENTER_US (CENTER_US),
        .SLEW_US   (SLEW_US)
    ) u_ch0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (xfer && !cmd_ch),
        .cmd_us_i (cmd_us),
        .step_i   (state_q == UPDATE),
        .pos_o    (pos0_q),
        .pos_d_o  (pos0_d)
    );

    servo_slew #(
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .CENTER_US (CENTER_US),
        .SLEW_US   (SLEW_US)
    ) u_ch1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (xfer && cmd_ch),
        .cmd_us_i (cmd_us),
        .step_i   (state_q == UPDATE),
        .pos_o    (pos1_q),
        .pos_d_o  (pos1_d)
    );

    assign servo_out = servo_q;
    assign pos_0     = pos0_q;
    assign pos_1     = pos1_q;

endmodule

// File: tb/tb_servo_pwm_scheduler.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_scheduler
// Self-checking bench. A reference model tracks, per clock, whether the
// scheduler is running and the clock index within the current frame; the
// first clock of every frame is the update clock. Targets and applied widths
// are plain integers updated by the clamp and slew rules. Pulse widths are
// measured per completed frame and compared with pos * clocks-per-us.
// Scaled parameters (2 MHz clock, 2100 us frame) keep the run short.
// -----------------------------------------------------------------------------
module tb_servo_pwm_scheduler;

    localparam int CLK_HZ     = 2_000_000;
    localparam int FRAME_US   = 2100;
    localparam int MIN_US     = 1000;
    localparam int MAX_US     = 2000;
    localparam int CENTER_US  = 1500;
    localparam int SLEW_US    = 20;
    localparam int DIV        = CLK_HZ / 1_000_000;
    localparam int FRAME_CLKS = FRAME_US * DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ch = 1'b0;
    logic [15:0] cmd_us = 16'd0;
    logic        cmd_ready;
    logic [1:0]  servo_out;
    logic [15:0] pos_0, pos_1;
    logic        frame_start;

    always #5 clk = ~clk;

    servo_pwm_scheduler #(
        .CLK_HZ    (CLK_HZ),
        .FRAME_US  (FRAME_US),
        .MIN_US    (MIN_US),
        .MAX_US    (MAX_US),
        .CENTER_US (CENTER_US),
        .SLEW_US   (SLEW_US)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_ch      (cmd_ch),
        .cmd_us      (cmd_us),
        .servo_out   (servo_out),
        .pos_0       (pos_0),
        .pos_1       (pos_1),
        .frame_start (frame_start)
    );

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // --------------------------------------------------------------- model
    bit run_m;        // scheduler running (not idle)
    int phase_m;      // clock index within the frame; 0 = update clock
    int pos_m [2];
    int tgt_m [2];
    bit acc_m;        // last edge transferred a command
    bit frame_full;   // current frame started at phase 0 and is uninterrupted
    int hi_cnt [2];
    int fs_cnt;
    int cyc_cnt = 0;

    function automatic int clamp_ref(input int v);
        if (v < MIN_US) return MIN_US;
        if (v > MAX_US) return MAX_US;
        return v;
    endfunction

    function automatic int slew_ref(input int p, input int t);
        int d = t - p;
        if (d <= SLEW_US && d >= -SLEW_US) return t;
        return (d > 0) ? p + SLEW_US : p - SLEW_US;
    endfunction

    task automatic model_reset();
        run_m      = 1'b0;
        phase_m    = 0;
        frame_full = 1'b0;
        acc_m      = 1'b0;
        for (int n = 0; n < 2; n++) begin
            pos_m[n] = CENTER_US;
            tgt_m[n] = CENTER_US;
        end
    endtask

    task automatic start_frame();
        hi_cnt[0]  = 0;
        hi_cnt[1]  = 0;
        fs_cnt     = 0;
        frame_full = 1'b1;
    endtask

    task automatic finish_frame();
        if (frame_full) begin
            check("width_ch0", hi_cnt[0], pos_m[0] * DIV);
            check("width_ch1", hi_cnt[1], pos_m[1] * DIV);
            check("fs_per_frame", fs_cnt, 1);
        end
    endtask

    // Called just after each rising edge with the inputs that edge sampled.
    task automatic model_edge();
        bit upd;
        acc_m = 1'b0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        upd = run_m && (phase_m == 0);
        if (cmd_valid && !upd) begin
            acc_m = 1'b1;
            tgt_m[cmd_ch] = clamp_ref(int'(cmd_us));
        end
        if (upd) begin
            for (int n = 0; n < 2; n++) pos_m[n] = slew_ref(pos_m[n], tgt_m[n]);
        end
        if (!enable) begin
            run_m      = 1'b0;
            phase_m    = 0;
            frame_full = 1'b0;
        end else if (!run_m) begin
            run_m   = 1'b1;
            phase_m = 0;
            start_frame();
        end else if (phase_m == FRAME_CLKS - 1) begin
            finish_frame();
            phase_m = 0;
            start_frame();
        end else begin
            phase_m++;
        end
    endtask

    task automatic sample();
        if (run_m) begin
            hi_cnt[0] += int'(servo_out[0]);
            hi_cnt[1] += int'(servo_out[1]);
            fs_cnt    += int'(frame_start);
            if (phase_m == 0) begin
                check("frame_start", frame_start, 1);
                check("ready_in_update", cmd_ready, 0);
            end
            if (phase_m == 1) begin
                check("pos_0", pos_0, pos_m[0]);
                check("pos_1", pos_1, pos_m[1]);
                check("ready_after_update", cmd_ready, 1);
            end
        end else begin
            check("idle_servo_out", servo_out, 0);
            check("idle_frame_start", frame_start, 0);
            check("idle_ready", cmd_ready, 1);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        cyc_cnt++;
        #1;
        sample();
    endtask

    // Advance at least one clock, then until the model reaches phase p.
    task automatic run_to_phase(input int p);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(run_m && phase_m == p) && n < FRAME_CLKS + 8);
    endtask

    task automatic send_cmd(input int ch, input int us, input bit hold);
        cmd_valid = 1'b1;
        cmd_ch    = ch[0];
        cmd_us    = us[15:0];
        for (int i = 0; i < 8; i++) begin
            check("cmd_ready", cmd_ready, (run_m && phase_m == 0) ? 0 : 1);
            cycle();
            if (acc_m) break;
        end
        check("cmd_accepted", acc_m, 1);
        if (!hold) cmd_valid = 1'b0;
    endtask

    initial begin
        #(99_000 * 10);
        $display("FAIL watchdog: cycle budget exceeded");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int c0;
        int exp_slew [4];
        exp_slew = '{1520, 1540, 1560, 1560};
        model_reset();

        // Reset state
        repeat (3) cycle();
        check("rst_servo_out", servo_out, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pos_0", pos_0, CENTER_US);
        check("rst_pos_1", pos_1, CENTER_US);
        reset_n = 1'b1;
        cycle();

        // Free-running with no commands: 1500 us pulses on both channels
        enable = 1'b1;
        cycle();
        check("first_frame_start", frame_start, 1);
        repeat (2 * FRAME_CLKS) cycle();
        check("idle_cmd_pos_0", pos_0, 1500);
        check("idle_cmd_pos_1", pos_1, 1500);

        // Slew of channel 0 toward 1560
        run_to_phase(500);
        send_cmd(0, 1560, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_to_phase(1);
            check("slew_pos_0", pos_0, exp_slew[k]);
        end

        // Clamping on channel 1
        run_to_phase(300);
        send_cmd(1, 3000, 1'b0);
        run_to_phase(1);
        check("clamp_hi_pos_1", pos_1, 1520);
        run_to_phase(300);
        send_cmd(1, 100, 1'b0);
        run_to_phase(1);
        check("clamp_lo_pos_1a", pos_1, 1500);
        run_to_phase(1);
        check("clamp_lo_pos_1b", pos_1, 1480);

        // cmd_valid held across a frame boundary
        run_to_phase(FRAME_CLKS - 2);
        c0 = cyc_cnt;
        send_cmd(0, 1700, 1'b1);
        send_cmd(1, 1200, 1'b1);
        send_cmd(0, 1650, 1'b1);
        send_cmd(1, 1300, 1'b0);
        check("batch_cycles", cyc_cnt - c0, 5);

        // Randomized commands at random points in the frame
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(100, 1800)) cycle();
            send_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, 3000)), 1'b0);
        end
        run_to_phase(0);
        run_to_phase(0);

        // Enable dropped mid-pulse at us_cnt = 700
        run_to_phase(700 * DIV);
        enable = 1'b0;
        cycle();
        check("en_drop_servo_out", servo_out, 0);
        repeat (5) cycle();
        enable = 1'b1;
        cycle();
        check("reenable_frame_start", frame_start, 1);
        run_to_phase(0);

        // Reset asserted mid-pulse with a command in flight
        run_to_phase(400);
        #2;
        reset_n   = 1'b0;
        cmd_valid = 1'b1;
        cmd_ch    = 1'b1;
        cmd_us    = 16'd1900;
        #1;
        check("rst_mid_servo_out", servo_out, 0);
        check("rst_mid_pos_0", pos_0, 1500);
        check("rst_mid_pos_1", pos_1, 1500);
        model_reset();
        repeat (3) cycle();
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        cycle();
        check("post_rst_frame_start", frame_start, 1);
        run_to_phase(1);
        check("post_rst_pos_1", pos_1, 1500);
        run_to_phase(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
